reorder_buffer: RTL and testbench

In-order retirement buffer for the out-of-order MIPS core. It sits downstream of rename/dispatch and beside the reservation stations. Each dispatched instruction gets a slot and a tag. Results are captured from the common data bus (CDB). Completed entries retire strictly in program order, driving the register-file write port and the rename free/commit path.

---
 rtl/rob_pkg.sv | 22 ++
 rtl/reorder_buffer.sv | 100 ++++++++++
 tb/tb_reorder_buffer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and default sizing, also used by the reservation
// stations and the CDB interface.
package rob_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = $clog2(ROB_DEPTH);
    localparam int PREG_W    = 6;
    localparam int DATA_W    = 32;

    typedef logic [TAG_W-1:0] rob_tag_t;
    // Pointer carries one extra wrap bit above the index.
    typedef logic [TAG_W:0]   rob_ptr_t;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              has_dest;
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at dispatch, captures CDB results,
// and retires completed entries one per cycle in program order.
module reorder_buffer #(
    parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
    parameter int TAG_W     = $clog2(ROB_DEPTH),
    parameter int PREG_W    = rob_pkg::PREG_W,
    parameter int DATA_W    = rob_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_dest,
    input  logic [PREG_W-1:0] alloc_preg,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              flush,
    output logic              commit_valid,
    output logic              reg_wr_en,
    output logic [PREG_W-1:0] reg_wr_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic [TAG_W:0]    count
);

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              has_dest;
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(ROB_DEPTH);

    logic [TAG_W:0]   head;
    logic [TAG_W:0]   tail;
    entry_t           entries [ROB_DEPTH];

    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             alloc_fire;
    logic             cdb_hit;
    logic             commit_fire;

    assign head_idx    = head[TAG_W-1:0];
    assign tail_idx    = tail[TAG_W-1:0];
    assign count       = tail - head;
    // Readiness comes from registered pointers only, so a same-cycle commit
    // never frees a slot for a same-cycle allocation.
    assign alloc_ready = (count < DEPTH_CNT);
    assign alloc_tag   = tail_idx;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign cdb_hit     = cdb_valid & entries[cdb_tag].busy;
    assign commit_fire = entries[head_idx].busy & entries[head_idx].done;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head         <= '0;
            tail         <= '0;
            commit_valid <= 1'b0;
            reg_wr_en    <= 1'b0;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
            // NOTE: only the control bits are cleared; preg/data are qualified
            // by busy/done, so the payload storage needs no reset.
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].busy <= 1'b0;
                entries[i].done <= 1'b0;
            end
        end else begin
            if (cdb_hit) begin
                entries[cdb_tag].data <= cdb_data;
                entries[cdb_tag].done <= 1'b1;
            end

            if (commit_fire) begin
                entries[head_idx].busy <= 1'b0;
                head                   <= head + 1'b1;
            end

            // The tail slot is never busy when allocation is allowed, so it
            // cannot collide with the CDB or commit writes above.
            if (alloc_fire) begin
                entries[tail_idx].busy     <= 1'b1;
                entries[tail_idx].done     <= 1'b0;
                entries[tail_idx].has_dest <= alloc_has_dest;
                entries[tail_idx].preg     <= alloc_preg;
                tail                       <= tail + 1'b1;
            end

            commit_valid <= commit_fire;
            reg_wr_en    <= commit_fire & entries[head_idx].has_dest;
            reg_wr_addr  <= commit_fire ? entries[head_idx].preg : '0;
            reg_wr_data  <= commit_fire ? entries[head_idx].data : '0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, out-of-order completion,
// in-order retirement, full/wrap behaviour, flush and stray CDB writes.
module tb_reorder_buffer;

    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = 3;
    localparam int PREG_W    = 6;
    localparam int DATA_W    = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alloc_valid;
    logic              alloc_ready;
    logic              alloc_has_dest;
    logic [PREG_W-1:0] alloc_preg;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              flush;
    logic              commit_valid;
    logic              reg_wr_en;
    logic [PREG_W-1:0] reg_wr_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic [TAG_W:0]    count;

    int n_tests = 0;
    int n_fail  = 0;

    reorder_buffer #(
        .ROB_DEPTH(ROB_DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_has_dest(alloc_has_dest), .alloc_preg(alloc_preg),
        .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush),
        .commit_valid(commit_valid), .reg_wr_en(reg_wr_en),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs changed 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid    = 1'b0;
        alloc_has_dest = 1'b0;
        alloc_preg     = '0;
        cdb_valid      = 1'b0;
        cdb_tag        = '0;
        cdb_data       = '0;
        flush          = 1'b0;
    endtask

    task automatic do_alloc(input logic has_dest, input logic [PREG_W-1:0] preg);
        alloc_valid    = 1'b1;
        alloc_has_dest = has_dest;
        alloc_preg     = preg;
        tick();
        alloc_valid    = 1'b0;
    endtask

    task automatic do_cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_count", count, 0);
        check("rst_ready", alloc_ready, 1);
        check("rst_tag", alloc_tag, 0);
        check("rst_commit", commit_valid, 0);
        check("rst_wr_en", reg_wr_en, 0);

        // Eight allocations fill the buffer; a ninth is ignored
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fill_tag%0d", i), alloc_tag, i);
            do_alloc(1'b1, 6'(i));
        end
        check("full_count", count, 8);
        check("full_ready", alloc_ready, 0);
        do_alloc(1'b1, 6'd9);
        check("ninth_count", count, 8);
        check("ninth_ready", alloc_ready, 0);
        do_flush();
        check("flush1_count", count, 0);

        // Out-of-order completion, in-order retirement
        do_alloc(1'b1, 6'd10);
        do_alloc(1'b1, 6'd11);
        do_alloc(1'b1, 6'd12);
        do_cdb(3'd2, 32'h22);
        check("ooo_no_commit_a", commit_valid, 0);
        do_cdb(3'd0, 32'h00);
        check("ooo_no_commit_b", commit_valid, 0);
        do_cdb(3'd1, 32'h11);
        check("ooo_c0_valid", commit_valid, 1);
        check("ooo_c0_addr", reg_wr_addr, 10);
        check("ooo_c0_data", reg_wr_data, 32'h00);
        tick();
        check("ooo_c1_valid", commit_valid, 1);
        check("ooo_c1_addr", reg_wr_addr, 11);
        check("ooo_c1_data", reg_wr_data, 32'h11);
        tick();
        check("ooo_c2_valid", commit_valid, 1);
        check("ooo_c2_en", reg_wr_en, 1);
        check("ooo_c2_addr", reg_wr_addr, 12);
        check("ooo_c2_data", reg_wr_data, 32'h22);
        tick();
        check("ooo_done_valid", commit_valid, 0);
        check("ooo_done_count", count, 0);

        // Entry without a destination still commits but does not write
        check("nodest_tag", alloc_tag, 3);
        do_alloc(1'b0, 6'd7);
        do_alloc(1'b1, 6'd5);
        do_cdb(3'd3, 32'hAA);
        do_cdb(3'd4, 32'h55);
        check("nodest_valid", commit_valid, 1);
        check("nodest_wr_en", reg_wr_en, 0);
        tick();
        check("dest_valid", commit_valid, 1);
        check("dest_wr_en", reg_wr_en, 1);
        check("dest_addr", reg_wr_addr, 5);
        check("dest_data", reg_wr_data, 32'h55);
        tick();
        check("dest_count", count, 0);

        // Full buffer with the head completing: alloc blocked on commit cycle
        do_flush();
        for (int i = 0; i < 8; i++) do_alloc(1'b1, 6'(20 + i));
        check("wrap_full_count", count, 8);
        do_cdb(3'd0, 32'hC0);
        alloc_valid    = 1'b1;
        alloc_has_dest = 1'b1;
        alloc_preg     = 6'd30;
        check("wrap_blocked_ready", alloc_ready, 0);
        tick();
        check("wrap_commit_valid", commit_valid, 1);
        check("wrap_commit_data", reg_wr_data, 32'hC0);
        check("wrap_count_7", count, 7);
        check("wrap_ready", alloc_ready, 1);
        check("wrap_tag", alloc_tag, 0);
        tick();
        alloc_valid = 1'b0;
        check("wrap_count_8", count, 8);
        check("wrap_ready_after", alloc_ready, 0);

        // Flush with five busy entries and a same-cycle CDB to tag 0
        do_flush();
        for (int i = 0; i < 5; i++) do_alloc(1'b1, 6'(40 + i));
        check("pre_flush_count", count, 5);
        flush     = 1'b1;
        cdb_valid = 1'b1;
        cdb_tag   = 3'd0;
        cdb_data  = 32'h99;
        tick();
        idle_inputs();
        check("flush_count", count, 0);
        check("flush_commit", commit_valid, 0);
        tick();
        check("flush_commit_later", commit_valid, 0);
        tick();
        check("flush_commit_later2", commit_valid, 0);
        check("flush_tag", alloc_tag, 0);

        // Stray CDB to a non-busy tag leaves no trace
        do_alloc(1'b1, 6'd0);
        do_alloc(1'b1, 6'd1);
        do_alloc(1'b1, 6'd2);
        do_cdb(3'd6, 32'h66);
        check("stray_count", count, 3);
        check("stray_commit", commit_valid, 0);
        do_cdb(3'd0, 32'h1);
        do_cdb(3'd1, 32'h2);
        do_cdb(3'd2, 32'h3);
        tick();
        tick();
        tick();
        check("stray_drain_count", count, 0);
        for (int i = 3; i < 7; i++) do_alloc(1'b1, 6'(i));
        do_cdb(3'd3, 32'h4);
        do_cdb(3'd4, 32'h5);
        do_cdb(3'd5, 32'h6);
        tick();
        tick();
        tick();
        check("stray_tag6_pending", count, 1);
        check("stray_tag6_no_commit", commit_valid, 0);
        do_cdb(3'd6, 32'h77);
        check("tag6_latency", commit_valid, 0);
        tick();
        check("tag6_valid", commit_valid, 1);
        check("tag6_addr", reg_wr_addr, 6);
        check("tag6_data", reg_wr_data, 32'h77);
        tick();
        check("tag6_once", commit_valid, 0);
        check("end_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
